arith_encoder_ctrl: RTL and testbench
=====================================

ARITH_ENCODER_CTRL -- requirements
Module: arith_encoder_ctrl

Interface
REQ-001 SHALL have parameter CTRL_RANGE_WIDTH, default 16, width of fl/fh.
REQ-002 SHALL have parameter CTRL_SYMBOL_WIDTH, default 4, symbol width; nsyms is CTRL_SYMBOL_WIDTH+1 bits.
REQ-003 SHALL have parameter CTRL_PIPE_DEPTH, default 2, encoder input-to-output latency in cycles.
REQ-004 SHALL have parameter CTRL_FIFO_DEPTH, default 4, input buffer entries (power of two).
REQ-005 SHALL have ports, clock and reset first:
- general_clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- frame_start, in, 1: start-of-frame pulse.
- frame_end, in, 1: last symbol has been offered.
- in_valid, in, 1: a symbol is offered.
- in_ready, out, 1: the offered symbol is accepted.
- in_fl, in_fh, in, CTRL_RANGE_WIDTH: symbol CDF bounds.
- in_symbol, in, CTRL_SYMBOL_WIDTH: symbol value.
- in_nsyms, in, CTRL_SYMBOL_WIDTH+1: alphabet size.
- enc_reset, out, 1: reset to the encoder datapath.
- enc_en, out, 1: encoder stage advance (clock enable).
- enc_fl, enc_fh, enc_symbol, enc_nsyms, out: operands issued to the encoder.
- enc_out_valid, out, 1: the encoder RANGE/LOW outputs are valid this cycle.
- busy, out, 1: the state is not IDLE.
- frame_done, out, 1: one-cycle completion pulse.

Function
REQ-006 SHALL implement the states IDLE, INIT, RUN, DRAIN and DONE.
REQ-007 IDLE->INIT on frame_start; frame_start SHALL be ignored in any other state.
REQ-008 INIT SHALL last exactly 1 cycle, with enc_reset=1 and enc_en=0, then go to RUN.
REQ-009 Handshake: a transfer SHALL occur when in_valid && in_ready; in_ready = (state==RUN) && !fifo_full && !end_seen, so there is no bypass when the FIFO is full.
REQ-010 In RUN, when the FIFO is non-empty, the controller SHALL pop one entry per cycle, drive it on enc_* and assert enc_en for that cycle.
REQ-011 When the FIFO is empty, enc_en SHALL be 0 and enc_* SHALL hold their last values, so the encoder stalls without inserting symbols.
REQ-012 A push and a pop in the same cycle SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo CTRL_FIFO_DEPTH.
REQ-013 frame_end SHALL set end_seen, which is sticky until DONE; frame_end arriving together with a transfer SHALL include that symbol.
REQ-014 RUN->DRAIN when end_seen && fifo empty; frame_end received with the FIFO already empty SHALL take this transition on the next cycle.
REQ-015 DRAIN SHALL assert enc_en for exactly CTRL_PIPE_DEPTH cycles with enc_* held, flushing the pipeline, then go to DONE.
REQ-016 enc_out_valid SHALL be enc_en of a symbol-issue cycle delayed by CTRL_PIPE_DEPTH cycles, implemented as a shift register that shifts only when enc_en=1; DRAIN cycles push 0 into it.
REQ-017 DONE SHALL assert frame_done for 1 cycle, clear end_seen, then go to IDLE.
REQ-018 A frame with zero symbols SHALL still pass through INIT, DRAIN and DONE with no enc_out_valid pulses.

Reset
REQ-019 While reset=1, all of the following SHALL hold from the next edge:
- state=IDLE
- FIFO pointers and occupancy = 0
- end_seen=0
- valid shift register = 0
- enc_en=0
- enc_reset=1
- in_ready=0
- busy=0
- frame_done=0
- enc_out_valid=0
- enc_* operands = 0
REQ-020 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse and discard all buffered symbols.
REQ-021 Outside reset and INIT, enc_reset SHALL be 0.

Configuration
REQ-022 Macro ARITH_CTRL_SYMBOL_COUNT_EN SHALL be supported.
- Defined: an additional output symbol_count, 16 bits, counts issued symbols, clears in INIT, saturates at 16'hFFFF, and holds its value through IDLE.
- Undefined: the port and the counter SHALL be absent, with no other behaviour change.

Structure
REQ-023 The state enum and default parameter constants SHALL reside in the shared package arith_ctrl_pkg.
REQ-024 The input buffer SHALL be a sub-module ctrl_sym_fifo, storing {fl, fh, symbol, nsyms} with push/pop/full/empty flags.

Verification
REQ-025 Reset, then frame_start, 3 symbols back-to-back, frame_end with the 3rd: enc_reset high 1 cycle, enc_en high for 3+2 cycles, enc_out_valid high exactly 3 cycles, frame_done 1 cycle later.
REQ-026 Hold the source valid for 6 symbols while the encoder issues: in_ready drops only when the FIFO holds 4 entries; all 6 issue in order with unchanged fl/fh/symbol/nsyms.
REQ-027 Symbols with 2-cycle gaps: enc_en=0 in the gaps, enc_* held, enc_out_valid count equals 5 for 5 symbols.
REQ-028 frame_start then immediate frame_end with no symbols: sequence INIT, RUN, DRAIN (2), DONE; zero enc_out_valid pulses; frame_done=1 once.
REQ-029 Reset asserted in RUN with 2 symbols buffered: state IDLE next cycle, in_ready=0, no frame_done, and the next frame sees an empty FIFO.
REQ-030 With ARITH_CTRL_SYMBOL_COUNT_EN defined, a 5-symbol frame gives symbol_count=5 after DONE; a new frame_start resets it to 0.

Source files
------------

// File: rtl/arith_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_ctrl_pkg
//  Description : Shared constants for the arithmetic-encoder controller:
//                controller state encodings, default parameter values and
//                a helper that sizes the packed operand word.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_ctrl_pkg;

    // Default configuration of the controller
    localparam int c_def_range_width  = 16;
    localparam int c_def_symbol_width = 4;
    localparam int c_def_pipe_depth   = 2;
    localparam int c_def_fifo_depth   = 4;

    // Saturation value of the optional issued-symbol counter
    localparam logic [15:0] c_sym_count_max = 16'hFFFF;

    // Controller state encoding
    typedef logic [2:0] ctrl_state_t;
    localparam ctrl_state_t c_st_idle  = 3'd0;
    localparam ctrl_state_t c_st_init  = 3'd1;
    localparam ctrl_state_t c_st_run   = 3'd2;
    localparam ctrl_state_t c_st_drain = 3'd3;
    localparam ctrl_state_t c_st_done  = 3'd4;

    // Width of one packed {fl, fh, symbol, nsyms} operand word
    function automatic int ctrl_op_width(input int range_w, input int sym_w);
        return 2 * range_w + 2 * sym_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_sym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sym_fifo
//  Description : Small synchronous FIFO buffering packed symbol operands
//                between the source handshake and the encoder issue stage.
//                DEPTH must be a power of two so the pointers wrap freely.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_sym_fifo #(
    parameter int DATA_WIDTH = 41,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem_q [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ptr_w-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w:0]      r_count_q,  w_count_d;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_full    = (r_count_q == (c_ptr_w + 1)'(DEPTH));
    assign o_empty   = (r_count_q == '0);
    assign o_rdata   = r_mem_q[r_rd_ptr_q];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer and occupancy update; simultaneous push and pop keeps the count
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_q[r_wr_ptr_q] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arith_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arith_encoder_ctrl
//  Description : Frame controller for a pipelined arithmetic encoder.
//                Buffers offered symbols, issues one per cycle with a clock
//                enable, flushes the pipeline at frame end and tracks which
//                encoder outputs carry real symbols.
//                Optional macro ARITH_CTRL_SYMBOL_COUNT_EN adds a saturating
//                16-bit symbol_count output of issued symbols.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_encoder_ctrl
    import arith_ctrl_pkg::*;
#(
    parameter int CTRL_RANGE_WIDTH  = c_def_range_width,
    parameter int CTRL_SYMBOL_WIDTH = c_def_symbol_width,
    parameter int CTRL_PIPE_DEPTH   = c_def_pipe_depth,
    parameter int CTRL_FIFO_DEPTH   = c_def_fifo_depth
) (
    input  logic                         general_clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic                         frame_end,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_RANGE_WIDTH-1:0]  in_fl,
    input  logic [CTRL_RANGE_WIDTH-1:0]  in_fh,
    input  logic [CTRL_SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [CTRL_SYMBOL_WIDTH:0]   in_nsyms,
    output logic                         enc_reset,
    output logic                         enc_en,
    output logic [CTRL_RANGE_WIDTH-1:0]  enc_fl,
    output logic [CTRL_RANGE_WIDTH-1:0]  enc_fh,
    output logic [CTRL_SYMBOL_WIDTH-1:0] enc_symbol,
    output logic [CTRL_SYMBOL_WIDTH:0]   enc_nsyms,
    output logic                         enc_out_valid,
    output logic                         busy,
    output logic                         frame_done
`ifdef ARITH_CTRL_SYMBOL_COUNT_EN
    ,
    output logic [15:0]                  symbol_count
`endif
);

    localparam int c_op_w    = ctrl_op_width(CTRL_RANGE_WIDTH, CTRL_SYMBOL_WIDTH);
    localparam int c_drain_w = $clog2(CTRL_PIPE_DEPTH + 1);

    ctrl_state_t                r_state_q,      w_state_d;
    logic                       r_end_seen_q,   w_end_seen_d;
    logic                       r_issue_q,      w_issue_d;
    logic                       r_enc_reset_q,  w_enc_reset_d;
    logic                       r_advanced_q,   w_advanced_d;
    logic [c_op_w-1:0]          r_enc_ops_q,    w_enc_ops_d;
    logic [CTRL_PIPE_DEPTH-1:0] r_valid_sr_q,   w_valid_sr_d;
    logic [c_drain_w-1:0]       r_drain_cnt_q,  w_drain_cnt_d;
    logic [CTRL_PIPE_DEPTH-1:0] w_sr_shift;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [c_op_w-1:0] w_fifo_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_enc_en;

    // No bypass: a symbol is only taken while the buffer has room
    assign in_ready = (r_state_q == c_st_run) && !w_fifo_full && !r_end_seen_q;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state_q == c_st_run) && !w_fifo_empty;

    // The encoder advances on a symbol issue or on every flush cycle
    assign w_enc_en      = r_issue_q || (r_state_q == c_st_drain);
    assign enc_en        = w_enc_en;
    assign enc_reset     = r_enc_reset_q;
    assign busy          = (r_state_q != c_st_idle);
    assign frame_done    = (r_state_q == c_st_done);
    // A valid result is presented once, right after the advance that produced it
    assign enc_out_valid = r_valid_sr_q[CTRL_PIPE_DEPTH-1] && r_advanced_q;
    assign {enc_fl, enc_fh, enc_symbol, enc_nsyms} = r_enc_ops_q;

    ctrl_sym_fifo #(
        .DATA_WIDTH (c_op_w),
        .DEPTH      (CTRL_FIFO_DEPTH)
    ) u_sym_fifo (
        .clk     (general_clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({in_fl, in_fh, in_symbol, in_nsyms}),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next shift-register contents: issue flag enters at bit 0
    generate
        if (CTRL_PIPE_DEPTH > 1) begin : g_sr_wide
            assign w_sr_shift = {r_valid_sr_q[CTRL_PIPE_DEPTH-2:0], r_issue_q};
        end else begin : g_sr_single
            assign w_sr_shift = r_issue_q;
        end
    endgenerate

    // Frame sequencing, operand issue and valid tracking
    always_comb begin
        w_state_d     = r_state_q;
        w_end_seen_d  = r_end_seen_q;
        w_drain_cnt_d = r_drain_cnt_q;
        case (r_state_q)
            c_st_idle: begin
                if (frame_start) begin
                    w_state_d = c_st_init;
                end
            end
            c_st_init: begin
                if (frame_end) begin
                    w_end_seen_d = 1'b1;
                end
                w_state_d = c_st_run;
            end
            c_st_run: begin
                if (frame_end) begin
                    w_end_seen_d = 1'b1;
                end
                if (r_end_seen_q && w_fifo_empty) begin
                    w_state_d     = c_st_drain;
                    w_drain_cnt_d = '0;
                end
            end
            c_st_drain: begin
                if (r_drain_cnt_q == c_drain_w'(CTRL_PIPE_DEPTH - 1)) begin
                    w_state_d = c_st_done;
                end else begin
                    w_drain_cnt_d = r_drain_cnt_q + 1'b1;
                end
            end
            c_st_done: begin
                w_end_seen_d = 1'b0;
                w_state_d    = c_st_idle;
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase

        w_enc_reset_d = (w_state_d == c_st_init);
        w_issue_d     = w_pop;
        w_enc_ops_d   = w_pop ? w_fifo_rdata : r_enc_ops_q;
        w_valid_sr_d  = w_enc_en ? w_sr_shift : r_valid_sr_q;
        w_advanced_d  = w_enc_en;
    end

    // Controller state registers
    always_ff @(posedge general_clk) begin
        if (reset) begin
            r_state_q     <= c_st_idle;
            r_end_seen_q  <= 1'b0;
            r_issue_q     <= 1'b0;
            r_enc_reset_q <= 1'b1;
            r_advanced_q  <= 1'b0;
            r_enc_ops_q   <= '0;
            r_valid_sr_q  <= '0;
            r_drain_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_end_seen_q  <= w_end_seen_d;
            r_issue_q     <= w_issue_d;
            r_enc_reset_q <= w_enc_reset_d;
            r_advanced_q  <= w_advanced_d;
            r_enc_ops_q   <= w_enc_ops_d;
            r_valid_sr_q  <= w_valid_sr_d;
            r_drain_cnt_q <= w_drain_cnt_d;
        end
    end

`ifdef ARITH_CTRL_SYMBOL_COUNT_EN
    logic [15:0] r_sym_count_q, w_sym_count_d;

    assign symbol_count = r_sym_count_q;

    // Issued-symbol count: cleared at frame start, saturating, held when idle
    always_comb begin
        w_sym_count_d = r_sym_count_q;
        if (r_state_q == c_st_init) begin
            w_sym_count_d = '0;
        end else if (w_pop && (r_sym_count_q != c_sym_count_max)) begin
            w_sym_count_d = r_sym_count_q + 16'd1;
        end
    end

    // Symbol counter register
    always_ff @(posedge general_clk) begin
        if (reset) begin
            r_sym_count_q <= '0;
        end else begin
            r_sym_count_q <= w_sym_count_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arith_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_encoder_ctrl
//  Description : Self-checking bench for arith_encoder_ctrl. A scoreboard
//                queue records accepted symbols and is drained as the
//                controller issues them; scenario tasks check sequencing.
//                Exercises symbol_count when ARITH_CTRL_SYMBOL_COUNT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_encoder_ctrl;

    localparam int RW   = 16;
    localparam int SW   = 4;
    localparam int PD   = 2;
    localparam int FD   = 4;
    localparam int c_ow = 2 * RW + 2 * SW + 1;

    logic          general_clk;
    logic          reset;
    logic          frame_start;
    logic          frame_end;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_fl;
    logic [RW-1:0] in_fh;
    logic [SW-1:0] in_symbol;
    logic [SW:0]   in_nsyms;
    logic          enc_reset;
    logic          enc_en;
    logic [RW-1:0] enc_fl;
    logic [RW-1:0] enc_fh;
    logic [SW-1:0] enc_symbol;
    logic [SW:0]   enc_nsyms;
    logic          enc_out_valid;
    logic          busy;
    logic          frame_done;
`ifdef ARITH_CTRL_SYMBOL_COUNT_EN
    logic [15:0]   symbol_count;
`endif

    logic [c_ow-1:0] ops;
    logic [c_ow-1:0] last_ops;
    logic [c_ow-1:0] exp_ops;
    logic [c_ow-1:0] sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_en, n_ov, n_done, n_rst;
    int first_en_cyc, last_en_cyc, last_ov_cyc, done_cyc;

    assign ops = {enc_fl, enc_fh, enc_symbol, enc_nsyms};

    arith_encoder_ctrl #(
        .CTRL_RANGE_WIDTH  (RW),
        .CTRL_SYMBOL_WIDTH (SW),
        .CTRL_PIPE_DEPTH   (PD),
        .CTRL_FIFO_DEPTH   (FD)
    ) dut (
        .general_clk   (general_clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_fl         (in_fl),
        .in_fh         (in_fh),
        .in_symbol     (in_symbol),
        .in_nsyms      (in_nsyms),
        .enc_reset     (enc_reset),
        .enc_en        (enc_en),
        .enc_fl        (enc_fl),
        .enc_fh        (enc_fh),
        .enc_symbol    (enc_symbol),
        .enc_nsyms     (enc_nsyms),
        .enc_out_valid (enc_out_valid),
        .busy          (busy),
        .frame_done    (frame_done)
`ifdef ARITH_CTRL_SYMBOL_COUNT_EN
        ,
        .symbol_count  (symbol_count)
`endif
    );

    initial general_clk = 1'b0;
    always #5 general_clk = ~general_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard and event monitor, sampled mid-cycle
    always @(negedge general_clk) begin
        cyc++;
        if (reset) begin
            last_ops = '0;
        end else begin
            if (enc_en) begin
                if (n_en == 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                n_en++;
                if (sb.size() != 0) begin
                    exp_ops = sb.pop_front();
                    checks++;
                    if (ops !== exp_ops) begin
                        errors++;
                        $display("FAIL issue_order got %h exp %h", ops, exp_ops);
                    end
                end
                last_ops = ops;
            end else begin
                checks++;
                if (ops !== last_ops) begin
                    errors++;
                    $display("FAIL operand_hold got %h exp %h", ops, last_ops);
                end
            end
            if (enc_out_valid) begin
                n_ov++;
                last_ov_cyc = cyc;
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (enc_reset) n_rst++;
            if (in_valid && in_ready) sb.push_back({in_fl, in_fh, in_symbol, in_nsyms});
        end
    end

    task automatic tick;
        @(posedge general_clk);
        #1;
    endtask

    task automatic clear_counts;
        n_en = 0; n_ov = 0; n_done = 0; n_rst = 0;
        first_en_cyc = 0; last_en_cyc = 0; last_ov_cyc = 0; done_cyc = 0;
    endtask

    task automatic drive_symbol;
        in_fl     = RW'($urandom);
        in_fh     = RW'($urandom);
        in_symbol = SW'($urandom);
        in_nsyms  = (SW + 1)'($urandom);
    endtask

    task automatic wait_done;
        for (int k = 0; k < 40 && n_done == 0; k++) tick;
        tick;
    endtask

    // Drive one frame of n symbols separated by gap idle cycles
    task automatic send_frame(input int n, input int gap);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        if (n == 0) begin
            frame_end = 1'b1;
            tick;
            frame_end = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            drive_symbol();
            frame_end = (i == n - 1);
            for (int g = 0; g < 50 && !in_ready; g++) tick;
            tick;
            in_valid  = 1'b0;
            frame_end = 1'b0;
            for (int g = 0; g < gap; g++) tick;
        end
        wait_done();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (enc_en !== 1'b0)        begin errors++; $display("FAIL rst_enc_en got %b exp 0", enc_en); end
        checks++; if (enc_reset !== 1'b1)     begin errors++; $display("FAIL rst_enc_reset got %b exp 1", enc_reset); end
        checks++; if (frame_done !== 1'b0)    begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
        checks++; if (enc_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", enc_out_valid); end
        checks++; if (ops !== '0)             begin errors++; $display("FAIL rst_operands got %h exp 0", ops); end
        reset = 1'b0;
        tick;
        checks++; if (enc_reset !== 1'b0)     begin errors++; $display("FAIL post_rst_enc_reset got %b exp 0", enc_reset); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL post_rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back;
        clear_counts();
        send_frame(3, 0);
        checks++; if (n_rst !== 1)  begin errors++; $display("FAIL b2b_enc_reset_cycles got %0d exp 1", n_rst); end
        checks++; if (n_en !== 5)   begin errors++; $display("FAIL b2b_enc_en_cycles got %0d exp 5", n_en); end
        checks++; if (last_en_cyc - first_en_cyc !== 4) begin errors++; $display("FAIL b2b_enc_en_span got %0d exp 4", last_en_cyc - first_en_cyc); end
        checks++; if (n_ov !== 3)   begin errors++; $display("FAIL b2b_out_valid got %0d exp 3", n_ov); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL b2b_frame_done got %0d exp 1", n_done); end
        checks++; if (done_cyc !== last_ov_cyc + 1) begin errors++; $display("FAIL b2b_done_timing got %0d exp %0d", done_cyc, last_ov_cyc + 1); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_unissued got %0d exp 0", sb.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
    endtask

    task automatic test_hold_valid;
        int occ;
        clear_counts();
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        occ = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_symbol();
            frame_end = (i == 5);
            checks++;
            if (in_ready !== (occ < FD)) begin
                errors++;
                $display("FAIL hold_in_ready[%0d] got %b exp %b", i, in_ready, occ < FD);
            end
            occ = occ + ((occ < FD) ? 1 : 0) - ((occ > 0) ? 1 : 0);
            tick;
        end
        in_valid  = 1'b0;
        frame_end = 1'b0;
        wait_done();
        checks++; if (n_ov !== 6)   begin errors++; $display("FAIL hold_out_valid got %0d exp 6", n_ov); end
        checks++; if (n_en !== 8)   begin errors++; $display("FAIL hold_enc_en got %0d exp 8", n_en); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL hold_frame_done got %0d exp 1", n_done); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL hold_unissued got %0d exp 0", sb.size()); end
    endtask

    task automatic test_gaps;
        clear_counts();
        send_frame(5, 2);
        checks++; if (n_ov !== 5)   begin errors++; $display("FAIL gap_out_valid got %0d exp 5", n_ov); end
        checks++; if (n_en !== 7)   begin errors++; $display("FAIL gap_enc_en got %0d exp 7", n_en); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL gap_frame_done got %0d exp 1", n_done); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL gap_unissued got %0d exp 0", sb.size()); end
    endtask

    task automatic test_empty_frame;
        // {enc_reset, enc_en, frame_done, busy, in_ready}: INIT, RUN, RUN, DRAIN, DRAIN, DONE, IDLE
        logic [4:0] exp_tab [7];
        logic [4:0] obs;
        exp_tab = '{5'b10010, 5'b00011, 5'b00010, 5'b01010, 5'b01010, 5'b00110, 5'b00000};
        clear_counts();
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int s = 0; s < 7; s++) begin
            frame_end = (s == 1);
            obs = {enc_reset, enc_en, frame_done, busy, in_ready};
            checks++;
            if (obs !== exp_tab[s]) begin
                errors++;
                $display("FAIL empty_seq[%0d] got %b exp %b", s, obs, exp_tab[s]);
            end
            tick;
        end
        frame_end = 1'b0;
        checks++; if (n_ov !== 0)   begin errors++; $display("FAIL empty_out_valid got %0d exp 0", n_ov); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL empty_frame_done got %0d exp 1", n_done); end
    endtask

    task automatic test_reset_mid_frame;
        clear_counts();
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            drive_symbol();
            tick;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        checks++; if (enc_en !== 1'b0)     begin errors++; $display("FAIL midrst_enc_en got %b exp 0", enc_en); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_frame_done got %b exp 0", frame_done); end
        sb.delete();
        tick;
        reset = 1'b0;
        tick;
        tick;
        checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", n_done); end
        clear_counts();
        send_frame(1, 0);
        checks++; if (n_ov !== 1)   begin errors++; $display("FAIL midrst_next_out_valid got %0d exp 1", n_ov); end
        checks++; if (n_en !== 3)   begin errors++; $display("FAIL midrst_next_enc_en got %0d exp 3", n_en); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL midrst_next_done got %0d exp 1", n_done); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL midrst_unissued got %0d exp 0", sb.size()); end
    endtask

`ifdef ARITH_CTRL_SYMBOL_COUNT_EN
    task automatic test_symbol_count;
        clear_counts();
        send_frame(5, 0);
        checks++; if (symbol_count !== 16'd5) begin errors++; $display("FAIL count_after_frame got %0d exp 5", symbol_count); end
        tick;
        checks++; if (symbol_count !== 16'd5) begin errors++; $display("FAIL count_idle_hold got %0d exp 5", symbol_count); end
        clear_counts();
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        checks++; if (symbol_count !== 16'd0) begin errors++; $display("FAIL count_cleared got %0d exp 0", symbol_count); end
        frame_end = 1'b1;
        tick;
        frame_end = 1'b0;
        wait_done();
    endtask
`endif

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        in_valid    = 1'b0;
        in_fl       = '0;
        in_fh       = '0;
        in_symbol   = '0;
        in_nsyms    = '0;
        clear_counts();
        test_reset();
        test_back_to_back();
        test_hold_valid();
        test_gaps();
        test_empty_frame();
        test_reset_mid_frame();
`ifdef ARITH_CTRL_SYMBOL_COUNT_EN
        test_symbol_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
